// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl - three-channel 8-bit PWM generator for the on-chip RGB LED driver.
//
// A prescaler produces one PWM tick every div+1 clocks, and an 8-bit PWM counter
// advances on each tick. Each channel has two duty registers:
//   target - captured from duty_x on the load strobe
//   active - the duty actually driving pwm_out
// The active duty changes only at a period wrap. It either jumps straight to the
// target or, with fade_en set, moves one LSB toward it.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   div        in   prescaler divide (tick every div+1 clk)
//   load       in   single-cycle strobe capturing duty_r/g/b into the targets
//   duty_r/g/b in   target duties
//   fade_en    in   1 = step active duty by +/-1 per period, 0 = jump to target
//   pwm_out    out  [0]=R, [1]=G, [2]=B PWM drive (registered)
//   period_end out  one-clk pulse per PWM period wrap (registered)
//   settled    out  all active duties equal their targets (registered)
module rgb_pwm_ctrl #(
    parameter int DIV_W = 16,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [PWM_W-1:0] duty_r,
    input  logic [PWM_W-1:0] duty_g,
    input  logic [PWM_W-1:0] duty_b,
    input  logic             fade_en,
    output logic [2:0]       pwm_out,
    output logic             period_end,
    output logic             settled
);

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0] PWM_ONE = {{(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0] PWM_MAX = {PWM_W{1'b1}};

    logic [DIV_W-1:0] pre_cnt_reg;
    logic [DIV_W-1:0] pre_cnt_next;
    logic [PWM_W-1:0] pwm_cnt_reg;
    logic [PWM_W-1:0] pwm_cnt_next;
    logic             tick;
    logic             wrap;

    logic [2:0][PWM_W-1:0] duty_vec;
    logic [2:0]            pwm_bit_next;
    logic [2:0]            match_next;

    logic [2:0] pwm_out_reg;
    logic       period_end_reg;
    logic       settled_reg;

    assign duty_vec = {duty_b, duty_g, duty_r};

    // A ">=" compare rather than "==" means that lowering div below the
    // running count forces a tick on the next cycle. The counter therefore
    // never has to roll over through the full DIV_W range.
    assign tick         = (pre_cnt_reg >= div);
    assign wrap         = tick && (pwm_cnt_reg == PWM_MAX);
    assign pre_cnt_next = tick ? '0 : pre_cnt_reg + DIV_ONE;
    assign pwm_cnt_next = tick ? pwm_cnt_reg + PWM_ONE : pwm_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_reg <= '0;
            pwm_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
            pwm_cnt_reg <= pwm_cnt_next;
        end
    end

    // Per-channel target/active duty pipeline.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_ch
            logic [PWM_W-1:0] target_reg;
            logic [PWM_W-1:0] target_next;
            logic [PWM_W-1:0] active_reg;
            logic [PWM_W-1:0] active_next;
            logic [PWM_W-1:0] tnext;

            // A load landing on the wrap cycle is honoured at that same wrap.
            assign tnext = load ? duty_vec[gi] : target_reg;

            always_comb begin
                target_next = target_reg;
                active_next = active_reg;
                if (load) begin
                    target_next = duty_vec[gi];
                end
                if (wrap) begin
                    if (!fade_en) begin
                        active_next = tnext;
                    end else if (active_reg < tnext) begin
                        active_next = active_reg + PWM_ONE;
                    end else if (active_reg > tnext) begin
                        active_next = active_reg - PWM_ONE;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    target_reg <= '0;
                    active_reg <= '0;
                end else begin
                    target_reg <= target_next;
                    active_reg <= active_next;
                end
            end

            // The compare uses the pre-wrap count and active values. pwm_out
            // therefore lags pwm_cnt by one clock, and a new duty shows up one
            // clock after the wrap, together with count 0.
            assign pwm_bit_next[gi] = (pwm_cnt_reg < active_reg);
            assign match_next[gi]   = (active_next == target_next);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_out_reg    <= 3'b000;
            period_end_reg <= 1'b0;
            settled_reg    <= 1'b1;
        end else begin
            pwm_out_reg    <= pwm_bit_next;
            period_end_reg <= wrap;
            settled_reg    <= &match_next;
        end
    end

    assign pwm_out    = pwm_out_reg;
    assign period_end = period_end_reg;
    assign settled    = settled_reg;

endmodule
